// File: rtl/ring16_monitor.sv
// ring16_monitor: locks onto a 16-bit one-hot rotating pattern, tracks the
// active bit and completed revolutions, and latches a fault on an illegal
// pattern, an illegal step or a stalled ring.
module ring16_monitor #(
  parameter int unsigned LOCK_STEPS  = 4,
  parameter int unsigned STALL_LIMIT = 16_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ring_in,
  input  logic        clear,
  output logic        locked,
  output logic        fault,
  output logic [1:0]  err_code,
  output logic [3:0]  pos,
  output logic        step_pulse,
  output logic [15:0] rev_count
);

  localparam logic [3:0]  LockSteps  = 4'(LOCK_STEPS);
  localparam logic [23:0] StallLimit = 24'(STALL_LIMIT);

  typedef enum logic [1:0] {StAcquire, StLocked, StFault} state_e;

  state_e      state;
  logic [15:0] prev;
  logic [3:0]  acq_cnt;
  logic [23:0] idle_cnt;

  logic        ring_event;
  logic        one_hot;
  logic        legal;
  logic [3:0]  ring_idx;
  logic [3:0]  acq_inc;
  logic [3:0]  pos_inc;
  logic [23:0] idle_inc;

  // Classify the sampled value against the previous one.
  always_comb begin
    ring_event = (ring_in != prev);
    one_hot    = (ring_in != 16'd0) && ((ring_in & (ring_in - 16'd1)) == 16'd0);
    // A one-hot rotation of prev always differs from prev, so event is implied.
    legal      = ring_event && one_hot && (ring_in == {prev[14:0], prev[15]});
    ring_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (ring_in[i]) ring_idx = 4'(i);
    end
    acq_inc    = acq_cnt + 4'd1;
    pos_inc    = pos + 4'd1;
    idle_inc   = idle_cnt + 24'd1;
  end

  // Monitor FSM with all status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StAcquire;
      prev       <= 16'd0;
      acq_cnt    <= 4'd0;
      idle_cnt   <= 24'd0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      err_code   <= 2'd0;
      pos        <= 4'd0;
      step_pulse <= 1'b0;
      rev_count  <= 16'd0;
    end else begin
      prev       <= ring_in;
      step_pulse <= 1'b0;
      if (clear) begin
        // clear wins over any lock or fault decision made this cycle
        state     <= StAcquire;
        acq_cnt   <= 4'd0;
        idle_cnt  <= 24'd0;
        locked    <= 1'b0;
        fault     <= 1'b0;
        err_code  <= 2'd0;
        pos       <= 4'd0;
        rev_count <= 16'd0;
      end else begin
        case (state)
          StAcquire: begin
            if (legal) begin
              if (acq_inc == LockSteps) begin
                state    <= StLocked;
                locked   <= 1'b1;
                pos      <= ring_idx;
                acq_cnt  <= 4'd0;
                idle_cnt <= 24'd0;
              end else begin
                acq_cnt <= acq_inc;
              end
            end else if (ring_event) begin
              acq_cnt <= 4'd0;
            end
          end
          StLocked: begin
            if (legal) begin
              step_pulse <= 1'b1;
              pos        <= pos_inc;
              idle_cnt   <= 24'd0;
              if (pos_inc == 4'd0) rev_count <= rev_count + 16'd1;
            end else if (ring_event) begin
              state    <= StFault;
              locked   <= 1'b0;
              fault    <= 1'b1;
              err_code <= one_hot ? 2'd2 : 2'd1;
            end else begin
              idle_cnt <= idle_inc;
              if (idle_inc == StallLimit) begin
                state    <= StFault;
                locked   <= 1'b0;
                fault    <= 1'b1;
                err_code <= 2'd3;
              end
            end
          end
          StFault: begin
            // Frozen until clear or rst.
          end
          default: begin
            state <= StAcquire;
          end
        endcase
      end
    end
  end

endmodule
